// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state, destination encodings and defaults for the RAM port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, DACC, IBURST, RESP} state_t;
  typedef enum logic {DST_I, DST_D} dest_t;
  localparam int WIDTH_DEF = 12;
  localparam int LINE_WORDS_DEF = 4;
endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant that remembers which side was served last
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_d,
  input  logic req_i,
  input  logic en,
  output logic gnt_d,
  output logic gnt_i
);
  logic last_i;
  // on contention serve the side that was not served last; reset favours data
  always_comb begin
    gnt_d = req_d && (!req_i || last_i);
    gnt_i = req_i && (!req_d || !last_i);
  end
  // remember the winner of each accepted grant
  always_ff @(posedge clk or posedge rst)
    if (rst) last_i <= 1'b1;
    else if (en && (gnt_d || gnt_i)) last_i <= gnt_i;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between icache line refills and single-word data accesses
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  localparam int IDXW = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ireq,
  input  logic [WIDTH-1:0] i_iaddr,
  output logic             o_ivalid,
  output logic [31:0]      o_idata,
  output logic [IDXW-1:0]  o_iidx,
  output logic             o_idone,
  input  logic             i_dreq,
  input  logic             i_dwe,
  input  logic [WIDTH-1:0] i_daddr,
  input  logic [31:0]      i_ddata,
  output logic             o_dvalid,
  output logic [31:0]      o_ddata,
  output logic             o_mem_we,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [31:0]      o_mem_data,
  input  logic [31:0]      i_mem_data
);
  localparam logic [IDXW-1:0] LAST = IDXW'(LINE_WORDS - 1);
  state_t state;
  dest_t ret_dest;
  logic ret_valid, ret_st, gnt_d, gnt_i;
  logic [IDXW-1:0] cnt, cnt_nx, ret_idx;
  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req_d(i_dreq),
    .req_i(i_ireq),
    .en   (state == IDLE),
    .gnt_d(gnt_d),
    .gnt_i(gnt_i)
  );
  // next burst word index; wraps inside the line so addresses never leave it
  always_comb cnt_nx = cnt + IDXW'(1);
  // FSM drives the RAM port a cycle ahead and tags each issued read in the return register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ret_valid <= 1'b0;
      ret_dest <= DST_D;
      ret_idx <= '0;
      ret_st <= 1'b0;
      o_mem_we <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
    end else begin
      o_mem_we <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
      ret_valid <= 1'b0;
      case (state)
        IDLE:
          if (gnt_d) begin
            state <= DACC;
            o_mem_we <= i_dwe;
            o_mem_addr <= i_daddr;
            o_mem_data <= i_dwe ? i_ddata : '0;
          end else if (gnt_i) begin
            state <= IBURST;
            cnt <= '0;
            o_mem_addr <= {i_iaddr[WIDTH-1:IDXW], {IDXW{1'b0}}};
          end
        DACC: begin
          state <= RESP;
          ret_valid <= 1'b1;
          ret_dest <= DST_D;
          ret_st <= o_mem_we;
        end
        IBURST: begin
          state <= (cnt == LAST) ? RESP : IBURST;
          ret_valid <= 1'b1;
          ret_dest <= DST_I;
          ret_idx <= cnt;
          ret_st <= 1'b0;
          cnt <= cnt_nx;
          o_mem_addr <= (cnt == LAST) ? '0 : {o_mem_addr[WIDTH-1:IDXW], cnt_nx};
        end
        default: state <= IDLE;
      endcase
    end
  // returned word is steered straight from the RAM to whichever side the tag names
  always_comb begin
    o_dvalid = ret_valid && (ret_dest == DST_D);
    o_ivalid = ret_valid && (ret_dest == DST_I);
    o_ddata = (o_dvalid && !ret_st) ? i_mem_data : '0;
    o_idata = o_ivalid ? i_mem_data : '0;
    o_iidx = o_ivalid ? ret_idx : '0;
    o_idone = o_ivalid && (ret_idx == LAST);
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the RAM port arbiter with a synchronous RAM model
module tb_mem_port_arbiter;
  typedef struct {bit is_i; logic [1:0] idx; logic [31:0] data;} rsp_t;
  typedef struct {logic [11:0] addr; logic we; logic [31:0] data;} acc_t;
  logic clk = 1'b0, rst = 1'b1;
  logic i_ireq = 1'b0, i_dreq = 1'b0, i_dwe = 1'b0;
  logic [11:0] i_iaddr = '0, i_daddr = '0;
  logic [31:0] i_ddata = '0, i_mem_data;
  logic o_ivalid, o_idone, o_dvalid, o_mem_we;
  logic [31:0] o_idata, o_ddata, o_mem_data;
  logic [1:0] o_iidx;
  logic [11:0] o_mem_addr;
  logic [31:0] mem [4096];
  logic [4095:0] wv = '0;
  rsp_t eq[$];
  acc_t aq[$];
  int n_checks = 0, n_fail = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_ireq(i_ireq), .i_iaddr(i_iaddr), .o_ivalid(o_ivalid), .o_idata(o_idata),
    .o_iidx(o_iidx), .o_idone(o_idone),
    .i_dreq(i_dreq), .i_dwe(i_dwe), .i_daddr(i_daddr), .i_ddata(i_ddata),
    .o_dvalid(o_dvalid), .o_ddata(o_ddata),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .i_mem_data(i_mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [11:0] a);
    case (a)
      12'h010: return 32'hDEADBEEF;
      12'h020: return 32'hAAAA0000;
      12'h021: return 32'hBBBB1111;
      12'h022: return 32'hCCCC2222;
      12'h023: return 32'hDDDD3333;
      default: return 32'h1000_0000 | 32'(a);
    endcase
  endfunction

  always @(posedge clk) begin
    i_mem_data <= wv[o_mem_addr] ? mem[o_mem_addr] : init_val(o_mem_addr);
    if (o_mem_we) begin
      mem[o_mem_addr] <= o_mem_data;
      wv[o_mem_addr] <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    acc_t a;
    if (!rst) begin
      if (o_idone && !o_ivalid) chk("idone_without_ivalid", o_idone, 0);
      if (o_dvalid || o_ivalid) begin
        if (eq.size() == 0) chk("spurious_rsp", {o_ivalid, o_dvalid}, 0);
        else begin
          e = eq.pop_front();
          chk("rsp_kind", {o_ivalid, o_dvalid}, e.is_i ? 2'b10 : 2'b01);
          if (e.is_i) begin
            chk("idata", o_idata, e.data);
            chk("iidx", o_iidx, e.idx);
            chk("idone", o_idone, e.idx == 2'd3);
          end else chk("ddata", o_ddata, e.data);
        end
      end
      if (o_mem_we || o_mem_addr != 0) begin
        if (aq.size() == 0) chk("spurious_mem_access", o_mem_addr, 0);
        else begin
          a = aq.pop_front();
          chk("mem_addr", o_mem_addr, a.addr);
          chk("mem_we", o_mem_we, a.we);
          chk("mem_data", o_mem_data, a.data);
        end
      end
    end
  end

  task automatic exp_d(input logic [11:0] a, input logic we, input logic [31:0] wd, input logic [31:0] rd);
    aq.push_back('{a, we, we ? wd : 32'h0});
    eq.push_back('{1'b0, 2'd0, we ? 32'h0 : rd});
  endtask

  task automatic exp_i(input logic [11:0] a, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int k = 0; k < 4; k++) begin
      aq.push_back('{{a[11:2], 2'(k)}, 1'b0, 32'h0});
      eq.push_back('{1'b1, 2'(k), d[k]});
    end
  endtask

  task automatic dreq_txn(input logic [11:0] a, input logic we, input logic [31:0] wd, input int exp_lat);
    int n = 0;
    i_daddr = a; i_dwe = we; i_ddata = wd; i_dreq = 1'b1;
    do begin @(negedge clk); n++; end while (!o_dvalid && n < 20);
    chk("dvalid_seen", o_dvalid, 1);
    if (exp_lat >= 0) chk("d_latency", n, exp_lat);
    i_dreq = 1'b0; i_dwe = 1'b0; i_ddata = '0;
    @(negedge clk);
  endtask

  task automatic ireq_txn(input logic [11:0] a, input int exp_lat);
    int n = 0;
    i_iaddr = a; i_ireq = 1'b1;
    do begin @(negedge clk); n++; end while (!o_idone && n < 30);
    chk("idone_seen", o_idone, 1);
    if (exp_lat >= 0) chk("i_latency", n, exp_lat);
    i_ireq = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk("reset_flags", {o_dvalid, o_ivalid, o_idone, o_mem_we, o_iidx}, 0);
    chk("reset_addr", o_mem_addr, 0);
    chk("reset_data", o_mem_data | o_ddata | o_idata, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk);
    exp_d(12'h010, 1'b0, 0, 32'hDEADBEEF);
    dreq_txn(12'h010, 1'b0, 0, 2);
    exp_i(12'h023, 32'hAAAA0000, 32'hBBBB1111, 32'hCCCC2222, 32'hDDDD3333);
    ireq_txn(12'h023, 5);
    exp_d(12'h020, 1'b1, 32'h12345678, 0);
    dreq_txn(12'h020, 1'b1, 32'h12345678, 2);
    exp_d(12'h020, 1'b0, 0, 32'h12345678);
    dreq_txn(12'h020, 1'b0, 0, 2);
    exp_i(12'hFFD, 32'h10000FFC, 32'h10000FFD, 32'h10000FFE, 32'h10000FFF);
    ireq_txn(12'hFFD, 5);
    reset_pulse();
    for (int r = 0; r < 2; r++) begin
      exp_d(12'h050, 1'b0, 0, 32'h10000050);
      exp_i(12'h030, 32'h10000030, 32'h10000031, 32'h10000032, 32'h10000033);
    end
    fork
      repeat (2) dreq_txn(12'h050, 1'b0, 0, -1);
      repeat (2) ireq_txn(12'h030, -1);
    join
    chk("contention_drained", eq.size(), 0);
    aq.push_back('{12'h040, 1'b0, 32'h0});
    aq.push_back('{12'h041, 1'b0, 32'h0});
    aq.push_back('{12'h042, 1'b0, 32'h0});
    eq.push_back('{1'b1, 2'd0, 32'h10000040});
    eq.push_back('{1'b1, 2'd1, 32'h10000041});
    i_iaddr = 12'h042; i_ireq = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flags", {o_dvalid, o_ivalid, o_idone, o_mem_we, o_iidx}, 0);
    chk("async_rst_addr", o_mem_addr, 0);
    chk("async_rst_data", o_idata | o_ddata | o_mem_data, 0);
    i_ireq = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", {o_ivalid, o_idone, o_dvalid, o_mem_we}, 0);
    end
    exp_d(12'h010, 1'b0, 0, 32'hDEADBEEF);
    dreq_txn(12'h010, 1'b0, 0, 2);
    repeat (3) @(negedge clk);
    chk("rsp_queue_empty", eq.size(), 0);
    chk("acc_queue_empty", aq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
